// File: rtl/servo_pkg.sv
// Shared types, FSM encodings and the position-to-width mapping for the servo PWM sequencer.
package servo_pkg;

    typedef logic [7:0] pos_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_START    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_STOPPING = 2'd3;

    localparam pos_t CENTER_POS = 8'd128;

    function automatic int unsigned width_from_pos(input pos_t pos, input int unsigned min_us,
                                                   input int unsigned us_per_step);
        return min_us + int'(pos) * us_per_step;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: slew-limited position, pulse width and registered PWM/at-target outputs.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US      = 1000,
    parameter int unsigned US_PER_STEP = 4,
    parameter int unsigned SLEW_STEP   = 2,
    parameter int unsigned WID_W       = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  pos_t             target,
    input  logic             frame_update,
    input  logic [WID_W-1:0] us_cnt,
    input  logic             run,
    input  logic             stopping,
    output logic             pwm_out,
    output logic             at_target
);

    localparam logic signed [8:0] STEP = 9'(SLEW_STEP);
    localparam logic [WID_W-1:0] CENTER_WIDTH =
        WID_W'(width_from_pos(CENTER_POS, MIN_US, US_PER_STEP));

    pos_t              cur_pos_q, cur_pos_d;
    logic [WID_W-1:0]  width_q, width_d;
    logic              pwm_q, at_target_q;
    logic signed [8:0] diff;
    logic              in_pulse;

    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, cur_pos_q});
        if (diff > STEP) begin
            cur_pos_d = cur_pos_q + pos_t'(SLEW_STEP);
        end else if (diff < -STEP) begin
            cur_pos_d = cur_pos_q - pos_t'(SLEW_STEP);
        end else begin
            cur_pos_d = target;
        end
        width_d  = WID_W'(width_from_pos(cur_pos_d, MIN_US, US_PER_STEP));
        in_pulse = (us_cnt < width_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_pos_q   <= CENTER_POS;
            width_q     <= CENTER_WIDTH;
            pwm_q       <= 1'b0;
            at_target_q <= (CENTER_POS == target);
        end else begin
            if (frame_update) begin
                cur_pos_q <= cur_pos_d;
                width_q   <= width_d;
            end
            // While stopping, only a pulse that is already high may continue.
            pwm_q       <= in_pulse && (run || (stopping && pwm_q));
            at_target_q <= (cur_pos_q == target);
        end
    end

    assign pwm_out   = pwm_q;
    assign at_target = at_target_q;

endmodule

// File: rtl/servo_pwm_sequencer.sv
// Frame timing (prescaler, microsecond counter, FSM) and fan-out to the per-channel slew units.
module servo_pwm_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned FRAME_US    = 20000,
    parameter int unsigned MIN_US      = 1000,
    parameter int unsigned US_PER_STEP = 4,
    parameter int unsigned SLEW_STEP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       servo_control,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start,
    output logic [NUM_CH-1:0] at_target,
    output logic              active
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_US);
    localparam int unsigned WID_W = (CNT_W > 11) ? CNT_W : 11;

    if (DIV < 1 || DIV * 1_000_000 != CLK_HZ) begin : g_bad_clk
        $error("CLK_HZ must be a nonzero multiple of 1 MHz");
    end
    if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_ch
        $error("NUM_CH must be 1..4");
    end
    if (MIN_US + 255 * US_PER_STEP >= FRAME_US) begin : g_bad_width
        $error("widest pulse must fit inside the frame");
    end
    if (SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_bad_slew
        $error("SLEW_STEP must be 1..255");
    end

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
    logic             counting, tick_us, boundary, frame_update;

    assign counting = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    assign tick_us  = counting && (presc_q == PRE_W'(DIV - 1));
    assign boundary = tick_us && (us_cnt_q == CNT_W'(FRAME_US - 1));

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        us_cnt_d     = us_cnt_q;
        frame_update = 1'b0;
        if (tick_us) begin
            presc_d  = '0;
            us_cnt_d = boundary ? '0 : us_cnt_q + CNT_W'(1);
        end else if (counting) begin
            presc_d = presc_q + PRE_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                presc_d  = '0;
                us_cnt_d = '0;
                if (enable) state_d = ST_START;
            end
            ST_START: begin
                presc_d      = '0;
                us_cnt_d     = '0;
                frame_update = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                if (boundary) begin
                    if (enable) frame_update = 1'b1;
                    else        state_d      = ST_IDLE;
                end else if (!enable) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (boundary)    state_d = ST_IDLE;
                else if (enable) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            us_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            us_cnt_q <= us_cnt_d;
        end
    end

    assign frame_start = frame_update;
    assign active      = counting;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        servo_slew_channel #(
            .MIN_US      (MIN_US),
            .US_PER_STEP (US_PER_STEP),
            .SLEW_STEP   (SLEW_STEP),
            .WID_W       (WID_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .target       (servo_control[8*n +: 8]),
            .frame_update (frame_update),
            .us_cnt       (WID_W'(us_cnt_q)),
            .run          (state_q == ST_RUN),
            .stopping     (state_q == ST_STOPPING),
            .pwm_out      (pwm_out[n]),
            .at_target    (at_target[n])
        );
    end

endmodule
